// File: rtl/modexp_seq_pkg.sv
// Shared types and helpers for the modexp stream sequencer.
package modexp_seq_pkg;

  localparam int MAX_WORDS_DEF = 128;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PTR_RST,
    S_LOAD_EXP,
    S_LOAD_MOD,
    S_LOAD_MSG,
    S_WAIT_RDY,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_FETCH,
    S_RD_OUT,
    S_FINISH
  } seq_state_e;

  // Exponent bit count to 32-bit word count, rounded up. 8191 bits would
  // need 256 words, so callers must range-check before trusting the result.
  function automatic logic [7:0] words_from_bits(input logic [12:0] bits);
    return 8'(({1'b0, bits} + 14'd31) >> 5);
  endfunction

endpackage

// File: rtl/modexp_seq_loader.sv
// Streams a fixed number of words from a valid/ready input into one memory
// write port; the caller muxes the write strobe onto the selected memory.
module modexp_seq_loader #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active_i,
  input  logic [CNT_W-1:0] target_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_data_i,
  output logic             in_ready_o,
  output logic             wr_o,
  output logic [31:0]      wdata_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_ready_o = active_i;
  assign wr_o       = active_i & in_valid_i;
  assign wdata_o    = in_data_i;
  assign last_o     = wr_o && (cnt_q == target_i - ONE);

  always_comb begin
    cnt_d = cnt_q;
    if (wr_o) cnt_d = last_o ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/modexp_stream_sequencer.sv
// Loads exponent, modulus and message into the modexp core from one input
// stream, starts the core, then drains the result onto an output stream.
module modexp_stream_sequencer
  import modexp_seq_pkg::*;
#(
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [12:0] exponent_length,
  input  logic [7:0]  modulus_length,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        len_err,
  output logic        core_start,
  input  logic        core_ready,
  output logic        exp_cs,
  output logic        exp_wr,
  output logic        exp_rst,
  output logic [31:0] exp_wdata,
  output logic        mod_cs,
  output logic        mod_wr,
  output logic        mod_rst,
  output logic [31:0] mod_wdata,
  output logic        msg_cs,
  output logic        msg_wr,
  output logic        msg_rst,
  output logic [31:0] msg_wdata,
  output logic        res_cs,
  output logic        res_rst,
  input  logic [31:0] res_rdata
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] e_words_q, n_words_q, cnt_q;
  logic             out_valid_q, out_last_q, len_err_q;
  logic [31:0]      out_data_q;

  logic             exp_ok, mod_ok, ld_active, ld_wr, ld_last;
  logic [CNT_W-1:0] ld_target;
  logic [31:0]      ld_wdata;

  // Range checks run on the raw inputs so an over-long exponent cannot wrap
  // through the 8-bit word count.
  assign exp_ok = (exponent_length != 13'd0) && (int'(exponent_length) <= MAX_WORDS * 32);
  assign mod_ok = (modulus_length != 8'd0) && (int'(modulus_length) <= MAX_WORDS);

  assign ld_active = (state_q == S_LOAD_EXP) || (state_q == S_LOAD_MOD) ||
                     (state_q == S_LOAD_MSG);
  assign ld_target = (state_q == S_LOAD_EXP) ? e_words_q : n_words_q;

  modexp_seq_loader #(.CNT_W(CNT_W)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .active_i   (ld_active),
    .target_i   (ld_target),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .wr_o       (ld_wr),
    .wdata_o    (ld_wdata),
    .last_o     (ld_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      e_words_q   <= '0;
      n_words_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      len_err_q   <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (exp_ok && mod_ok) begin
              e_words_q <= CNT_W'(words_from_bits(exponent_length));
              n_words_q <= CNT_W'(modulus_length);
              cnt_q     <= '0;
              state_q   <= S_PTR_RST;
            end else begin
              len_err_q <= 1'b1;
            end
          end
        end
        S_PTR_RST:  state_q <= S_LOAD_EXP;
        S_LOAD_EXP: if (ld_last) state_q <= S_LOAD_MOD;
        S_LOAD_MOD: if (ld_last) state_q <= S_LOAD_MSG;
        S_LOAD_MSG: if (ld_last) state_q <= S_WAIT_RDY;
        S_WAIT_RDY: if (core_ready) state_q <= S_START;
        S_START:    state_q <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (!core_ready) state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (core_ready) state_q <= S_RD_FETCH;
        S_RD_FETCH: begin
          // read data for the current pointer is valid now
          out_valid_q <= 1'b1;
          out_data_q  <= res_rdata;
          out_last_q  <= (cnt_q == n_words_q - ONE);
          state_q     <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              cnt_q   <= '0;
              state_q <= S_FINISH;
            end else begin
              cnt_q   <= cnt_q + ONE;
              state_q <= S_RD_FETCH;
            end
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done       = (state_q == S_FINISH);
  assign len_err    = len_err_q;
  assign core_start = (state_q == S_START);

  assign exp_rst = (state_q == S_PTR_RST);
  assign mod_rst = (state_q == S_PTR_RST);
  assign msg_rst = (state_q == S_PTR_RST);
  assign res_rst = (state_q == S_PTR_RST);

  assign exp_cs    = ld_wr && (state_q == S_LOAD_EXP);
  assign exp_wr    = exp_cs;
  assign exp_wdata = exp_cs ? ld_wdata : '0;
  assign mod_cs    = ld_wr && (state_q == S_LOAD_MOD);
  assign mod_wr    = mod_cs;
  assign mod_wdata = mod_cs ? ld_wdata : '0;
  assign msg_cs    = ld_wr && (state_q == S_LOAD_MSG);
  assign msg_wr    = msg_cs;
  assign msg_wdata = msg_cs ? ld_wdata : '0;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign res_cs    = (state_q == S_RD_OUT) && out_ready;

endmodule

// File: tb/tb_modexp_stream_sequencer.sv
// Bench for modexp_stream_sequencer: mock modexp core plus a word-slicing
// reference model of the load order and result drain.
module tb_modexp_stream_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [12:0] exponent_length = '0;
  logic [7:0]  modulus_length = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last, busy, done, len_err, core_start;
  logic        core_ready = 1'b1;
  logic        exp_cs, exp_wr, exp_rst, mod_cs, mod_wr, mod_rst, msg_cs, msg_wr, msg_rst;
  logic [31:0] exp_wdata, mod_wdata, msg_wdata;
  logic        res_cs, res_rst;
  logic [31:0] res_rdata = '0;

  modexp_stream_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .exponent_length(exponent_length),
    .modulus_length(modulus_length), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .len_err(len_err), .core_start(core_start), .core_ready(core_ready),
    .exp_cs(exp_cs), .exp_wr(exp_wr), .exp_rst(exp_rst), .exp_wdata(exp_wdata),
    .mod_cs(mod_cs), .mod_wr(mod_wr), .mod_rst(mod_rst), .mod_wdata(mod_wdata),
    .msg_cs(msg_cs), .msg_wr(msg_wr), .msg_rst(msg_rst), .msg_wdata(msg_wdata),
    .res_cs(res_cs), .res_rst(res_rst), .res_rdata(res_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // mock core: result memory with 1-cycle registered read, ready/busy handshake
  logic [31:0] res_mem [0:255];
  logic [7:0]  rptr = '0;
  int          core_lat = 0;

  always @(posedge clk) begin
    if (res_rst) begin
      rptr <= 8'd0;
      res_rdata <= res_mem[0];
    end else if (res_cs) begin
      rptr <= rptr + 8'd1;
      res_rdata <= res_mem[rptr + 8'd1];
    end else begin
      res_rdata <= res_mem[rptr];
    end
  end

  always @(posedge clk) begin
    if (core_start) begin
      core_ready <= 1'b0;
      core_lat <= int'($urandom_range(1, 5));
    end else if (!core_ready) begin
      if (core_lat == 0) core_ready <= 1'b1;
      else core_lat <= core_lat - 1;
    end
  end

  // observation logs
  logic [31:0] exp_log[$], mod_log[$], msg_log[$], out_log[$];
  bit          last_log[$];
  int n_start = 0, n_done = 0, n_lenerr = 0, n_ptrrst = 0, n_partial = 0;
  int n_rescs = 0, stab_err = 0;
  logic        prev_ov = 1'b0, prev_ol = 1'b0, prev_acc = 1'b0;
  logic [31:0] prev_od = '0;

  always @(posedge clk) begin
    if (exp_cs && exp_wr) exp_log.push_back(exp_wdata);
    if (mod_cs && mod_wr) mod_log.push_back(mod_wdata);
    if (msg_cs && msg_wr) msg_log.push_back(msg_wdata);
    if (out_valid && out_ready) begin
      out_log.push_back(out_data);
      last_log.push_back(out_last);
    end
    if (core_start) n_start <= n_start + 1;
    if (done) n_done <= n_done + 1;
    if (len_err) n_lenerr <= n_lenerr + 1;
    if (res_cs) n_rescs <= n_rescs + 1;
    if (exp_rst && mod_rst && msg_rst && res_rst) n_ptrrst <= n_ptrrst + 1;
    else if (exp_rst || mod_rst || msg_rst || res_rst) n_partial <= n_partial + 1;
    if (!rst && prev_ov && !prev_acc &&
        (!out_valid || out_data !== prev_od || out_last !== prev_ol))
      stab_err <= stab_err + 1;
    prev_ov  <= out_valid;
    prev_od  <= out_data;
    prev_ol  <= out_last;
    prev_acc <= out_valid && out_ready;
  end

  // transaction driver state shared with the tests
  logic [31:0] words[$];
  int  b_exp, b_mod, b_msg, b_out, b_start, b_done, b_rescs, b_ptr, b_lenerr;
  bit  ptr_after_go;
  int  stall_cs_delta;
  bit  stall_ov_held;
  bit  stall_od_same;
  bit  stall_seen;

  // Caller fills words (E+2N+1 entries, last one is an excess word) and res_mem.
  task automatic run_txn(input int elen, input int n, input bit gaps, input bit stall,
                         input bit extra_go, output bit timed_out);
    int total, done0;
    total    = (elen + 31) / 32 + 2 * n;
    b_exp    = exp_log.size();
    b_mod    = mod_log.size();
    b_msg    = msg_log.size();
    b_out    = out_log.size();
    b_start  = n_start;
    b_rescs  = n_rescs;
    b_ptr    = n_ptrrst;
    b_lenerr = n_lenerr;
    done0    = n_done;
    b_done   = n_done;
    stall_seen = 1'b0;
    @(negedge clk);
    go = 1'b1;
    exponent_length = 13'(elen);
    modulus_length = 8'(n);
    @(negedge clk);
    go = 1'b0;
    ptr_after_go = exp_rst && mod_rst && msg_rst && res_rst;
    fork
      begin : pusher
        int cyc, acc;
        cyc = 0;
        while (n_done == done0 && cyc < 4000) begin
          acc = (exp_log.size() - b_exp) + (mod_log.size() - b_mod) + (msg_log.size() - b_msg);
          if (acc > total) acc = total;
          in_data  = words[acc];
          in_valid = (acc >= total || !gaps) ? 1'b1 : 1'($urandom_range(0, 1));
          go       = (extra_go && (cyc == 3 || cyc == 40)) ? 1'b1 : 1'b0;
          @(negedge clk);
          cyc++;
        end
        in_valid = 1'b0;
        go = 1'b0;
      end
      begin : drainer
        int cyc, cs0;
        logic [31:0] od0;
        cyc = 0;
        while (n_done == done0 && cyc < 4000) begin
          if (stall && !stall_seen && out_valid) begin
            stall_seen = 1'b1;
            out_ready = 1'b0;
            cs0 = n_rescs;
            od0 = out_data;
            repeat (10) @(negedge clk);
            stall_cs_delta = n_rescs - cs0;
            stall_ov_held  = out_valid;
            stall_od_same  = (out_data === od0);
            cyc += 10;
          end
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    timed_out = (n_done == done0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || len_err !== 1'b0) begin
      failures++; $display("FAIL reset_status busy=%b done=%b len_err=%b required 0", busy, done, len_err); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0) begin
      failures++; $display("FAIL reset_stream in_ready=%b out_valid=%b out_last=%b out_data=%h required 0", in_ready, out_valid, out_last, out_data); end
    checks++; if ({core_start, exp_cs, exp_wr, exp_rst, mod_cs, mod_wr, mod_rst, msg_cs, msg_wr, msg_rst, res_cs, res_rst} !== 12'd0) begin
      failures++; $display("FAIL reset_core_lines got nonzero required all 0"); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    logic [31:0] ex[6];
    words.delete();
    for (int i = 1; i <= 7; i++) words.push_back(32'(i));
    res_mem[0] = 32'hA;
    res_mem[1] = 32'hB;
    run_txn(64, 2, 1'b0, 1'b0, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout done not seen required done"); end
    checks++; if (ptr_after_go !== 1'b1) begin failures++; $display("FAIL basic_ptr_rst got %b required 1", ptr_after_go); end
    ex = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    checks++; if (exp_log.size() - b_exp != 2 || mod_log.size() - b_mod != 2 || msg_log.size() - b_msg != 2) begin
      failures++; $display("FAIL basic_counts exp=%0d mod=%0d msg=%0d required 2 2 2", exp_log.size() - b_exp, mod_log.size() - b_mod, msg_log.size() - b_msg);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; if (exp_log[b_exp+i] !== ex[i] || mod_log[b_mod+i] !== ex[2+i] || msg_log[b_msg+i] !== ex[4+i]) begin
          failures++; $display("FAIL basic_words[%0d] exp=%h mod=%h msg=%h required %h %h %h", i, exp_log[b_exp+i], mod_log[b_mod+i], msg_log[b_msg+i], ex[i], ex[2+i], ex[4+i]); end
      end
    end
    checks++; if (n_start - b_start != 1) begin failures++; $display("FAIL basic_start got %0d required 1", n_start - b_start); end
    checks++; if (out_log.size() - b_out != 2) begin
      failures++; $display("FAIL basic_out_count got %0d required 2", out_log.size() - b_out);
    end else begin
      checks++; if (out_log[b_out] !== 32'hA || out_log[b_out+1] !== 32'hB || last_log[b_out] !== 1'b0 || last_log[b_out+1] !== 1'b1) begin
        failures++; $display("FAIL basic_out got %h/%b %h/%b required 0000000a/0 0000000b/1", out_log[b_out], last_log[b_out], out_log[b_out+1], last_log[b_out+1]); end
    end
    checks++; if (n_done - b_done != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_done pulses=%0d busy=%b required 1 0", n_done - b_done, busy); end
  endtask

  task automatic test_e33();
    bit to;
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom);
    res_mem[0] = $urandom;
    run_txn(33, 1, 1'b1, 1'b0, 1'b0, to);
    checks++; if (to) begin failures++; $display("FAIL e33_timeout done not seen required done"); end
    checks++; if (exp_log.size() - b_exp != 2 || mod_log.size() - b_mod != 1 || msg_log.size() - b_msg != 1) begin
      failures++; $display("FAIL e33_counts exp=%0d mod=%0d msg=%0d required 2 1 1", exp_log.size() - b_exp, mod_log.size() - b_mod, msg_log.size() - b_msg);
    end else begin
      checks++; if (exp_log[b_exp+1] !== words[1] || mod_log[b_mod] !== words[2] || msg_log[b_msg] !== words[3]) begin
        failures++; $display("FAIL e33_words exp1=%h mod=%h msg=%h required %h %h %h", exp_log[b_exp+1], mod_log[b_mod], msg_log[b_msg], words[1], words[2], words[3]); end
    end
    in_valid = 1'b1;
    in_data = words[4];
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL e33_in_ready got %b required 0", in_ready); end
    in_valid = 1'b0;
    checks++; if (out_log.size() - b_out != 1 || last_log[out_log.size()-1] !== 1'b1) begin
      failures++; $display("FAIL e33_out count=%0d required 1 with last", out_log.size() - b_out); end
  endtask

  task automatic test_len_err();
    int elens[5] = '{64, 64, 0, 4097, 8191};
    int ns[5]    = '{0, 129, 2, 2, 1};
    int s0;
    s0 = n_start;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      go = 1'b1;
      exponent_length = 13'(elens[k]);
      modulus_length = 8'(ns[k]);
      @(negedge clk);
      go = 1'b0;
      checks++; if (len_err !== 1'b1 || busy !== 1'b0) begin
        failures++; $display("FAIL len_err_pulse case %0d len_err=%b busy=%b required 1 0", k, len_err, busy); end
      @(negedge clk);
      checks++; if (len_err !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL len_err_width case %0d len_err=%b busy=%b required 0 0", k, len_err, busy); end
    end
    checks++; if (n_start != s0) begin failures++; $display("FAIL len_err_start got %0d required 0", n_start - s0); end
  endtask

  task automatic test_stall();
    bit to;
    int elen;
    elen = int'($urandom_range(1, 200));
    words.delete();
    for (int i = 0; i < (elen + 31) / 32 + 9; i++) words.push_back($urandom);
    for (int i = 0; i < 4; i++) res_mem[i] = $urandom;
    run_txn(elen, 4, 1'b1, 1'b1, 1'b0, to);
    checks++; if (to || !stall_seen) begin failures++; $display("FAIL stall_run timeout=%b stall_seen=%b required 0 1", to, stall_seen); end
    checks++; if (stall_cs_delta != 0 || !stall_ov_held || !stall_od_same) begin
      failures++; $display("FAIL stall_hold res_cs=%0d valid_held=%b data_same=%b required 0 1 1", stall_cs_delta, stall_ov_held, stall_od_same); end
    checks++; if (n_rescs - b_rescs != 4) begin failures++; $display("FAIL stall_res_cs got %0d required 4", n_rescs - b_rescs); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL stall_stability got %0d required 0", stab_err); end
    checks++; if (out_log.size() - b_out != 4) begin
      failures++; $display("FAIL stall_out_count got %0d required 4", out_log.size() - b_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (out_log[b_out+i] !== res_mem[i] || last_log[b_out+i] !== (i == 3)) begin
          failures++; $display("FAIL stall_out[%0d] got %h/%b required %h/%b", i, out_log[b_out+i], last_log[b_out+i], res_mem[i], (i == 3)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int t = 0; t < 2; t++) begin
      words.delete();
      for (int i = 0; i < 2 + 6 + 1; i++) words.push_back($urandom);
      for (int i = 0; i < 3; i++) res_mem[i] = $urandom;
      run_txn(50, 3, 1'b0, 1'b0, 1'b1, to);
      checks++; if (to) begin failures++; $display("FAIL b2b_timeout txn %0d", t); end
      checks++; if (n_start - b_start != 1 || n_lenerr != b_lenerr) begin
        failures++; $display("FAIL b2b_go_ignored starts=%0d len_err=%0d required 1 0", n_start - b_start, n_lenerr - b_lenerr); end
      checks++; if (out_log.size() - b_out != 3 || out_log[out_log.size()-1] !== res_mem[2] || msg_log[msg_log.size()-1] !== words[7]) begin
        failures++; $display("FAIL b2b_data out_count=%0d required 3", out_log.size() - b_out); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int m0, cyc;
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back($urandom);
    @(negedge clk);
    go = 1'b1; exponent_length = 13'd32; modulus_length = 8'd3;
    @(negedge clk);
    go = 1'b0;
    m0 = mod_log.size();
    cyc = 0;
    in_valid = 1'b1;
    in_data = 32'h5A5A_0001;
    while (mod_log.size() == m0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (mod_log.size() == m0) begin failures++; $display("FAIL rstmid_reach no mod write seen required LOAD_MOD"); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({in_ready, mod_cs, mod_wr, busy, out_valid, core_start} !== 6'd0 || mod_wdata !== 32'd0) begin
      failures++; $display("FAIL rstmid_async in_ready=%b mod_cs=%b mod_wr=%b busy=%b mod_wdata=%h required 0", in_ready, mod_cs, mod_wr, busy, mod_wdata); end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) res_mem[i] = $urandom;
    run_txn(32, 3, 1'b1, 1'b0, 1'b0, to);
    checks++; if (to || ptr_after_go !== 1'b1 || n_ptrrst - b_ptr != 1 || n_partial != 0) begin
      failures++; $display("FAIL rstmid_restart timeout=%b ptr_after_go=%b ptr_pulses=%0d partial=%0d required 0 1 1 0", to, ptr_after_go, n_ptrrst - b_ptr, n_partial); end
    checks++; if (exp_log.size() - b_exp != 1 || exp_log[b_exp] !== words[0] || mod_log.size() - b_mod != 3 || mod_log[b_mod+2] !== words[3]) begin
      failures++; $display("FAIL rstmid_load exp_count=%0d mod_count=%0d required 1 3", exp_log.size() - b_exp, mod_log.size() - b_mod); end
    checks++; if (out_log.size() - b_out != 3 || out_log[b_out] !== res_mem[0]) begin
      failures++; $display("FAIL rstmid_out count=%0d required 3", out_log.size() - b_out); end
  endtask

  task automatic test_random();
    bit to;
    int elen, n, e, bad;
    for (int t = 0; t < 5; t++) begin
      if (t == 4) begin elen = 4096; n = 128; end
      else begin elen = int'($urandom_range(1, 700)); n = int'($urandom_range(1, 9)); end
      e = (elen + 31) / 32;
      words.delete();
      for (int i = 0; i < e + 2 * n + 1; i++) words.push_back($urandom);
      for (int i = 0; i < n; i++) res_mem[i] = $urandom;
      run_txn(elen, n, t != 4, 1'b0, 1'b0, to);
      checks++; if (to) begin failures++; $display("FAIL rand_timeout txn %0d elen=%0d n=%0d", t, elen, n); end
      checks++; if (exp_log.size() - b_exp != e || mod_log.size() - b_mod != n || msg_log.size() - b_msg != n || out_log.size() - b_out != n) begin
        failures++; $display("FAIL rand_counts txn %0d exp=%0d mod=%0d msg=%0d out=%0d required %0d %0d %0d %0d", t,
          exp_log.size() - b_exp, mod_log.size() - b_mod, msg_log.size() - b_msg, out_log.size() - b_out, e, n, n, n);
      end else begin
        bad = 0;
        for (int i = 0; i < e; i++) if (exp_log[b_exp+i] !== words[i]) bad++;
        for (int i = 0; i < n; i++) begin
          if (mod_log[b_mod+i] !== words[e+i]) bad++;
          if (msg_log[b_msg+i] !== words[e+n+i]) bad++;
          if (out_log[b_out+i] !== res_mem[i] || last_log[b_out+i] !== (i == n - 1)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rand_data txn %0d wrong_words=%0d required 0", t, bad); end
      end
      checks++; if (n_start - b_start != 1 || n_done - b_done != 1) begin
        failures++; $display("FAIL rand_pulses txn %0d start=%0d done=%0d required 1 1", t, n_start - b_start, n_done - b_done); end
    end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL rand_stability got %0d required 0", stab_err); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) res_mem[i] = '0;
    test_reset();
    test_basic();
    test_e33();
    test_len_err();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
